// File: rtl/move_ctrl.sv
// Command generator for the falling-block position stage: synchronizes buttons,
// runs gravity and left/right auto-repeat, and issues at most one command pulse per cycle.
module move_ctrl #(
  parameter int CNT_W      = 25,
  parameter int GRAV_TICKS = 25000000,
  parameter int SOFT_TICKS = 2500000,
  parameter int DAS_DELAY  = 8000000,
  parameter int DAS_RATE   = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic err,
  input  logic pause,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_rot,
  input  logic btn_down,
  output logic drop,
  output logic left,
  output logic right,
  output logic ro
);

  localparam logic [CNT_W-1:0] GRAV_LIM = CNT_W'(GRAV_TICKS - 1);
  localparam logic [CNT_W-1:0] SOFT_LIM = CNT_W'(SOFT_TICKS - 1);
  localparam logic [CNT_W-1:0] DAS_LIM  = CNT_W'(DAS_DELAY - 1);
  localparam logic [CNT_W-1:0] DAS_LOAD = CNT_W'(DAS_DELAY - DAS_RATE);

  // Button bit order everywhere: 0 left, 1 right, 2 rot, 3 down.
  logic [3:0]       s1;
  logic [3:0]       s2;
  logic [2:0]       s3;
  logic [2:0]       ev;
  logic             both;

  logic [CNT_W-1:0] gcnt;
  logic [CNT_W-1:0] gcnt_nxt;
  logic [CNT_W-1:0] glim;
  logic             grav_fire;

  logic [CNT_W-1:0] das_l;
  logic [CNT_W-1:0] das_r;
  logic [CNT_W-1:0] das_l_nxt;
  logic [CNT_W-1:0] das_r_nxt;
  logic             rep_l;
  logic             rep_r;

  // Command bit order: 0 drop, 1 left, 2 right, 3 ro (also the priority order).
  logic [3:0]       pend;
  logic [3:0]       pend_set;
  logic [3:0]       issue;
  logic [3:0]       cmd_q;

  assign ev   = s2[2:0] & ~s3;
  assign both = s2[0] & s2[1];

  assign glim      = s2[3] ? SOFT_LIM : GRAV_LIM;
  assign grav_fire = (gcnt >= glim);
  assign gcnt_nxt  = grav_fire ? '0 : gcnt + CNT_W'(1);

  // Returns {repeat_pulse, next_count}. The threshold is DAS_DELAY-1 so the
  // first repeat lands exactly DAS_DELAY edges after the press event.
  function automatic logic [CNT_W:0] das_step(input logic [CNT_W-1:0] cnt,
                                              input logic evt,
                                              input logic held,
                                              input logic blocked);
    das_step = {1'b0, {CNT_W{1'b0}}};
    if (!evt && held && !blocked) begin
      if (cnt >= DAS_LIM) das_step = {1'b1, DAS_LOAD};
      else                das_step = {1'b0, cnt + CNT_W'(1)};
    end
  endfunction

  assign {rep_l, das_l_nxt} = das_step(das_l, ev[0], s2[0], both);
  assign {rep_r, das_r_nxt} = das_step(das_r, ev[1], s2[1], both);

  assign pend_set = {ev[2], ev[1] | rep_r, ev[0] | rep_l, grav_fire};

  always_comb begin
    issue = 4'b0000;
    if      (pend[0]) issue = 4'b0001;
    else if (pend[1]) issue = 4'b0010;
    else if (pend[2]) issue = 4'b0100;
    else if (pend[3]) issue = 4'b1000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= '0;
      s2    <= '0;
      s3    <= '0;
      gcnt  <= '0;
      das_l <= '0;
      das_r <= '0;
      pend  <= '0;
      cmd_q <= '0;
    end else begin
      // Synchronizers free-run so a button held across pause/err yields no event.
      s1 <= {btn_down, btn_rot, btn_right, btn_left};
      s2 <= s1;
      s3 <= s2[2:0];
      if (err) begin
        gcnt  <= '0;
        das_l <= '0;
        das_r <= '0;
        pend  <= '0;
        cmd_q <= '0;
      end else if (pause) begin
        das_l <= '0;
        das_r <= '0;
        pend  <= '0;
        cmd_q <= '0;
      end else begin
        gcnt  <= gcnt_nxt;
        das_l <= das_l_nxt;
        das_r <= das_r_nxt;
        pend  <= (pend & ~issue) | pend_set;
        cmd_q <= issue;
      end
    end
  end

  assign drop  = cmd_q[0];
  assign left  = cmd_q[1];
  assign right = cmd_q[2];
  assign ro    = cmd_q[3];

endmodule
